// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the branch target buffer entry layout.
// The BTB index width is shared with the local-history predictor's pc[5:2] indexing.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int BTB_IDX_W = 4;
    localparam int BTB_TAG_W = 30 - BTB_IDX_W;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        word_t                target;
    } btb_entry_t;

endpackage

// File: rtl/btb_tag_array.sv
// Direct-mapped BTB storage: one async read port, one write port.
// Only the valid bits are reset; tag and target are don't-care while invalid.
module btb_tag_array
    import cpu_types_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output word_t            rd_target_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  word_t            wr_target_i
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    word_t            target_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

    // No write-to-read bypass: a same-cycle lookup returns the old entry.
    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];

endmodule

// File: rtl/branch_target_buffer.sv
// Fetch-stage branch target buffer: lookup and next-PC prediction in fetch,
// resolution check, redirect PC and hit/miss statistics in MEM.
module branch_target_buffer
    import cpu_types_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t pc,
    input  logic  takebranch,
    input  word_t pcmem,
    input  logic  exmembeq_o,
    input  logic  exmembne_o,
    input  logic  changepc_branch,
    input  word_t branchtarget_mem,
    input  logic  predtaken_mem,
    input  word_t predtarget_mem,
    output logic  btbhit,
    output logic  predtaken,
    output word_t npc_pred,
    output logic  mispredict,
    output word_t npc_fix,
    output word_t hitcount,
    output word_t misscount
);

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    word_t            rd_target;
    logic             resolve;
    logic             update;
    word_t            hitcount_q, hitcount_d;
    word_t            misscount_q, misscount_d;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^{pc[1:0], pcmem[1:0]};

    btb_tag_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_array (
        .clk_i       (CLK),
        .rst_ni      (nRST),
        .rd_idx_i    (pc[IDX_W+1:2]),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
        .wr_en_i     (update),
        .wr_idx_i    (pcmem[IDX_W+1:2]),
        .wr_tag_i    (pcmem[31:IDX_W+2]),
        .wr_target_i (branchtarget_mem)
    );

    assign btbhit    = rd_valid && (rd_tag == pc[31:IDX_W+2]);
    assign predtaken = btbhit && takebranch;
    assign npc_pred  = predtaken ? rd_target : pc + 32'd4;

    assign resolve = ihit && (exmembeq_o || exmembne_o);
    // Not-taken resolutions leave the table alone; direction belongs to the predictor.
    assign update  = resolve && changepc_branch;

    assign mispredict = resolve &&
        ((changepc_branch != predtaken_mem) ||
         (changepc_branch && predtaken_mem && (predtarget_mem != branchtarget_mem)));
    assign npc_fix = changepc_branch ? branchtarget_mem : pcmem + 32'd4;

    always_comb begin
        hitcount_d  = hitcount_q;
        misscount_d = misscount_q;
        if (resolve) begin
            if (mispredict) begin
                if (misscount_q != '1) misscount_d = misscount_q + 32'd1;
            end else begin
                if (hitcount_q != '1) hitcount_d = hitcount_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hitcount_q  <= '0;
            misscount_q <= '0;
        end else begin
            hitcount_q  <= hitcount_d;
            misscount_q <= misscount_d;
        end
    end

    assign hitcount  = hitcount_q;
    assign misscount = misscount_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer with hand-computed expected values.
module tb_branch_target_buffer;

    logic        clk;
    logic        nrst;
    logic        ihit;
    logic [31:0] pc;
    logic        takebranch;
    logic [31:0] pcmem;
    logic        exmembeq;
    logic        exmembne;
    logic        changepc_branch;
    logic [31:0] branchtarget_mem;
    logic        predtaken_mem;
    logic [31:0] predtarget_mem;
    logic        btbhit;
    logic        predtaken;
    logic [31:0] npc_pred;
    logic        mispredict;
    logic [31:0] npc_fix;
    logic [31:0] hitcount;
    logic [31:0] misscount;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_buffer dut (
        .CLK              (clk),
        .nRST             (nrst),
        .ihit             (ihit),
        .pc               (pc),
        .takebranch       (takebranch),
        .pcmem            (pcmem),
        .exmembeq_o       (exmembeq),
        .exmembne_o       (exmembne),
        .changepc_branch  (changepc_branch),
        .branchtarget_mem (branchtarget_mem),
        .predtaken_mem    (predtaken_mem),
        .predtarget_mem   (predtarget_mem),
        .btbhit           (btbhit),
        .predtaken        (predtaken),
        .npc_pred         (npc_pred),
        .mispredict       (mispredict),
        .npc_fix          (npc_fix),
        .hitcount         (hitcount),
        .misscount        (misscount)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] a, input logic tb);
        pc         = a;
        takebranch = tb;
        #1;
    endtask

    task automatic resolve(input logic eq, input logic ne, input logic [31:0] pm,
                           input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        exmembeq         = eq;
        exmembne         = ne;
        pcmem            = pm;
        changepc_branch  = taken;
        branchtarget_mem = tgt;
        predtaken_mem    = ptaken;
        predtarget_mem   = ptgt;
        #1;
    endtask

    task automatic idle_mem();
        exmembeq = 1'b0;
        exmembne = 1'b0;
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        ihit = 1'b0;
        pc = '0; takebranch = 1'b0;
        pcmem = '0; exmembeq = 1'b0; exmembne = 1'b0;
        changepc_branch = 1'b0; branchtarget_mem = '0;
        predtaken_mem = 1'b0; predtarget_mem = '0;

        // 1. reset state
        lookup(32'h40, 1'b1);
        check("rst_btbhit", {31'd0, btbhit}, 32'd0);
        check("rst_predtaken", {31'd0, predtaken}, 32'd0);
        check("rst_npc_pred", npc_pred, 32'h44);
        check("rst_hitcount", hitcount, 32'd0);
        check("rst_misscount", misscount, 32'd0);
        #1 nrst = 1'b1;
        step();

        // 2. taken BEQ at 0x44 -> 0x100, predicted not-taken
        ihit = 1'b1;
        lookup(32'h44, 1'b1);
        resolve(1'b1, 1'b0, 32'h44, 1'b1, 32'h100, 1'b0, 32'h48);
        check("t2_same_cycle_miss", {31'd0, btbhit}, 32'd0);
        check("t2_mispredict", {31'd0, mispredict}, 32'd1);
        check("t2_npc_fix", npc_fix, 32'h100);
        step();
        idle_mem();
        check("t2_misscount", misscount, 32'd1);
        check("t2_mispredict_idle", {31'd0, mispredict}, 32'd0);
        lookup(32'h44, 1'b1);
        check("t2_hit", {31'd0, btbhit}, 32'd1);
        check("t2_predtaken", {31'd0, predtaken}, 32'd1);
        check("t2_npc_taken", npc_pred, 32'h100);
        lookup(32'h44, 1'b0);
        check("t2_hit_nt", {31'd0, btbhit}, 32'd1);
        check("t2_predtaken_nt", {31'd0, predtaken}, 32'd0);
        check("t2_npc_nt", npc_pred, 32'h48);

        // 3. alias at idx 1; 5. same-cycle lookup sees old entry
        lookup(32'h84, 1'b1);
        check("t3_alias_miss", {31'd0, btbhit}, 32'd0);
        check("t3_alias_npc", npc_pred, 32'h88);
        resolve(1'b0, 1'b1, 32'h84, 1'b1, 32'h200, 1'b0, 32'h88);
        lookup(32'h44, 1'b1);
        check("t5_old_entry_hit", {31'd0, btbhit}, 32'd1);
        check("t5_old_entry_npc", npc_pred, 32'h100);
        step();
        idle_mem();
        check("t3_misscount", misscount, 32'd2);
        check("t5_new_entry_evicts", {31'd0, btbhit}, 32'd0);
        check("t5_new_entry_npc", npc_pred, 32'h48);
        lookup(32'h84, 1'b1);
        check("t3_bne_hit", {31'd0, btbhit}, 32'd1);
        check("t3_bne_npc", npc_pred, 32'h200);

        // 4. direction mispredict, then correct prediction
        resolve(1'b1, 1'b0, 32'h44, 1'b0, 32'h100, 1'b1, 32'h100);
        check("t4_dir_mispredict", {31'd0, mispredict}, 32'd1);
        check("t4_npc_fix_nt", npc_fix, 32'h48);
        step();
        idle_mem();
        check("t4_misscount", misscount, 32'd3);
        check("t4_hitcount_hold", hitcount, 32'd0);
        check("t4_nt_no_write", {31'd0, btbhit}, 32'd1);
        resolve(1'b1, 1'b0, 32'h44, 1'b1, 32'h100, 1'b1, 32'h100);
        check("t4_correct", {31'd0, mispredict}, 32'd0);
        check("t4_npc_fix_t", npc_fix, 32'h100);
        step();
        idle_mem();
        check("t4_hitcount", hitcount, 32'd1);
        check("t4_misscount_hold", misscount, 32'd3);
        lookup(32'h44, 1'b1);
        check("t4_rewrite_npc", npc_pred, 32'h100);

        // wrong target with right direction
        resolve(1'b1, 1'b0, 32'h44, 1'b1, 32'h180, 1'b1, 32'h100);
        check("t4_target_mispredict", {31'd0, mispredict}, 32'd1);
        step();
        idle_mem();
        check("t4_target_misscount", misscount, 32'd4);
        check("t4_target_npc", npc_pred, 32'h180);

        // 5. resolve with ihit=0 has no effect
        ihit = 1'b0;
        resolve(1'b1, 1'b0, 32'h84, 1'b1, 32'h300, 1'b0, 32'h88);
        check("t5_stall_mispredict", {31'd0, mispredict}, 32'd0);
        step();
        check("t5_stall_hitcount", hitcount, 32'd1);
        check("t5_stall_misscount", misscount, 32'd4);
        lookup(32'h84, 1'b1);
        check("t5_stall_no_write", {31'd0, btbhit}, 32'd0);
        lookup(32'h44, 1'b1);
        check("t5_stall_keep", npc_pred, 32'h180);

        // 32-bit wrap of pc+4 and pcmem+4
        resolve(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        check("wrap_npc_fix", npc_fix, 32'h0);
        lookup(32'hFFFF_FFFC, 1'b1);
        check("wrap_npc_pred", npc_pred, 32'h0);
        idle_mem();

        // 6. asynchronous reset mid-run
        lookup(32'h44, 1'b1);
        check("t6_pre_hit", {31'd0, btbhit}, 32'd1);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("t6_async_miss", {31'd0, btbhit}, 32'd0);
        check("t6_async_npc", npc_pred, 32'h48);
        check("t6_async_hitcount", hitcount, 32'd0);
        check("t6_async_misscount", misscount, 32'd0);
        #1 nrst = 1'b1;
        step();
        check("t6_after_release", {31'd0, btbhit}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #20000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
